// File: rtl/rv_iopmp_mc_transaction_logic.sv
// Multi-channel IOPMP transaction logic: round-robin grant, windowed entry sweep
// with lowest-index first match, per-channel response and error-capture pulse.
module rv_iopmp_mc_transaction_logic #(
  parameter int ADDR_WIDTH             = 64,
  parameter int SID_WIDTH              = 8,
  parameter int NUMBER_ENTRIES         = 40,
  parameter int NUMBER_ENTRY_ANALYZERS = 16,
  parameter int NUM_CHANNELS           = 2,
  parameter int OFFS_WIDTH             = $clog2(NUMBER_ENTRIES) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               iopmp_enabled_i,
  input  logic                               cfg_changed_i,
  input  logic [NUM_CHANNELS-1:0]            req_valid_i,
  output logic [NUM_CHANNELS-1:0]            req_ready_o,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CHANNELS*SID_WIDTH-1:0]  req_sid_i,
  input  logic [NUM_CHANNELS*2-1:0]          req_access_i,
  output logic [NUM_CHANNELS-1:0]            rsp_valid_o,
  input  logic [NUM_CHANNELS-1:0]            rsp_ready_i,
  output logic                               rsp_allow_o,
  output logic                               win_valid_o,
  output logic [OFFS_WIDTH-1:0]              win_offset_o,
  output logic [ADDR_WIDTH-1:0]              chk_addr_o,
  output logic [SID_WIDTH-1:0]               chk_sid_o,
  output logic [1:0]                         chk_access_o,
  input  logic [NUMBER_ENTRY_ANALYZERS-1:0]  entry_match_i,
  input  logic [NUMBER_ENTRY_ANALYZERS-1:0]  entry_allow_i,
  input  logic [NUMBER_ENTRY_ANALYZERS-1:0]  entry_sid_ok_i,
  output logic                               err_valid_o,
  output logic [2:0]                         err_type_o,
  output logic [15:0]                        err_eid_o,
  output logic [SID_WIDTH-1:0]               err_sid_o,
  output logic [ADDR_WIDTH-1:0]              err_addr_o
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int LANE_W = (NUMBER_ENTRY_ANALYZERS > 1) ? $clog2(NUMBER_ENTRY_ANALYZERS) : 1;
  localparam logic [2:0] ETYPE_NO_HIT = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SID_WIDTH-1:0]    sid_q, sid_d;
  logic [1:0]              access_q, access_d;
  logic [OFFS_WIDTH-1:0]   offset_q, offset_d;
  logic                    allow_q, allow_d;
  logic                    err_pend_q, err_pend_d;
  logic [2:0]              etype_q, etype_d;
  logic [15:0]             eid_q, eid_d;

  logic                    any_req;
  logic [CH_W-1:0]         grant_idx;
  int                      arb_cand;

  logic [NUMBER_ENTRY_ANALYZERS-1:0] lane_valid;
  logic [NUMBER_ENTRY_ANALYZERS-1:0] hit;
  logic                              hit_found;
  logic [LANE_W-1:0]                 hit_lane;
  logic                              last_win;

  // Round-robin: scanning downwards leaves the channel closest to rr_ptr as winner.
  always_comb begin
    arb_cand  = 0;
    any_req   = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      arb_cand = int'(rr_ptr_q) + i;
      if (arb_cand >= NUM_CHANNELS) arb_cand = arb_cand - NUM_CHANNELS;
      if (req_valid_i[arb_cand]) begin
        any_req   = 1'b1;
        grant_idx = CH_W'(arb_cand);
      end
    end
  end

  // Lanes past the end of the table (ragged last window) never produce a hit.
  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < NUMBER_ENTRY_ANALYZERS; i++) begin
      lane_valid[i] = (int'(offset_q) + i) < NUMBER_ENTRIES;
    end
    hit       = entry_match_i & entry_sid_ok_i & lane_valid;
    hit_found = 1'b0;
    hit_lane  = '0;
    for (int i = NUMBER_ENTRY_ANALYZERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_found = 1'b1;
        hit_lane  = LANE_W'(i);
      end
    end
  end

  assign last_win = (int'(offset_q) + NUMBER_ENTRY_ANALYZERS) >= NUMBER_ENTRIES;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    sid_d       = sid_q;
    access_d    = access_q;
    offset_d    = offset_q;
    allow_d     = allow_q;
    err_pend_d  = err_pend_q;
    etype_d     = etype_q;
    eid_d       = eid_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req && rst_ni) begin
          req_ready_o[grant_idx] = 1'b1;
          grant_d    = grant_idx;
          rr_ptr_d   = (int'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + CH_W'(1);
          addr_d     = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          sid_d      = req_sid_i[int'(grant_idx)*SID_WIDTH +: SID_WIDTH];
          access_d   = req_access_i[int'(grant_idx)*2 +: 2];
          offset_d   = '0;
          allow_d    = 1'b0;
          err_pend_d = 1'b0;
          etype_d    = '0;
          eid_d      = '0;
          state_d    = iopmp_enabled_i ? SCAN : RESP;
        end
      end
      SCAN: begin
        // A table write invalidates partial results, so the sweep starts over.
        if (!iopmp_enabled_i) begin
          allow_d = 1'b0;
          state_d = RESP;
        end else if (cfg_changed_i) begin
          offset_d = '0;
        end else if (hit_found) begin
          state_d = RESP;
          if (entry_allow_i[hit_lane]) begin
            allow_d = 1'b1;
          end else begin
            allow_d    = 1'b0;
            err_pend_d = 1'b1;
            etype_d    = {1'b0, access_q};
            eid_d      = 16'(offset_q) + 16'(hit_lane);
          end
        end else if (last_win) begin
          state_d    = RESP;
          allow_d    = 1'b0;
          err_pend_d = 1'b1;
          etype_d    = ETYPE_NO_HIT;
          eid_d      = '0;
        end else begin
          offset_d = offset_q + OFFS_WIDTH'(NUMBER_ENTRY_ANALYZERS);
        end
      end
      RESP: begin
        err_pend_d = 1'b0;
        if (rsp_ready_i[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      sid_q      <= '0;
      access_q   <= '0;
      offset_q   <= '0;
      allow_q    <= 1'b0;
      err_pend_q <= 1'b0;
      etype_q    <= '0;
      eid_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      sid_q      <= sid_d;
      access_q   <= access_d;
      offset_q   <= offset_d;
      allow_q    <= allow_d;
      err_pend_q <= err_pend_d;
      etype_q    <= etype_d;
      eid_q      <= eid_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[grant_q] = 1'b1;
  end

  assign rsp_allow_o  = (state_q == RESP) && allow_q;
  assign win_valid_o  = (state_q == SCAN);
  assign win_offset_o = offset_q;
  assign chk_addr_o   = addr_q;
  assign chk_sid_o    = sid_q;
  assign chk_access_o = access_q;

  // err_pend_q is cleared after the first RESP cycle, making err_valid_o a pulse.
  assign err_valid_o = (state_q == RESP) && err_pend_q;
  assign err_type_o  = err_valid_o ? etype_q : '0;
  assign err_eid_o   = err_valid_o ? eid_q : '0;
  assign err_sid_o   = err_valid_o ? sid_q : '0;
  assign err_addr_o  = err_valid_o ? addr_q : '0;

endmodule

// File: tb/tb_rv_iopmp_mc_transaction_logic.sv
// Testbench for rv_iopmp_mc_transaction_logic: table-driven analyzer model,
// directed scenarios plus randomized transactions checked against a reference model.
module tb_rv_iopmp_mc_transaction_logic;

  localparam int AW      = 64;
  localparam int SW      = 8;
  localparam int NE      = 40;
  localparam int NA      = 16;
  localparam int NC      = 2;
  localparam int OW      = $clog2(NE) + 1;
  localparam int NUM_WIN = (NE + NA - 1) / NA;
  localparam int TBL     = NUM_WIN * NA;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 iopmp_enabled_i = 1'b1;
  logic                 cfg_changed_i = 1'b0;
  logic [NC-1:0]        req_valid_i = '0;
  logic [NC-1:0]        req_ready_o;
  logic [NC*AW-1:0]     req_addr_i = '0;
  logic [NC*SW-1:0]     req_sid_i = '0;
  logic [NC*2-1:0]      req_access_i = '0;
  logic [NC-1:0]        rsp_valid_o;
  logic [NC-1:0]        rsp_ready_i = '0;
  logic                 rsp_allow_o;
  logic                 win_valid_o;
  logic [OW-1:0]        win_offset_o;
  logic [AW-1:0]        chk_addr_o;
  logic [SW-1:0]        chk_sid_o;
  logic [1:0]           chk_access_o;
  logic [NA-1:0]        entry_match_i;
  logic [NA-1:0]        entry_allow_i;
  logic [NA-1:0]        entry_sid_ok_i;
  logic                 err_valid_o;
  logic [2:0]           err_type_o;
  logic [15:0]          err_eid_o;
  logic [SW-1:0]        err_sid_o;
  logic [AW-1:0]        err_addr_o;

  always #5 clk_i = ~clk_i;

  rv_iopmp_mc_transaction_logic #(
    .ADDR_WIDTH(AW), .SID_WIDTH(SW), .NUMBER_ENTRIES(NE),
    .NUMBER_ENTRY_ANALYZERS(NA), .NUM_CHANNELS(NC), .OFFS_WIDTH(OW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .iopmp_enabled_i(iopmp_enabled_i),
    .cfg_changed_i(cfg_changed_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_sid_i(req_sid_i), .req_access_i(req_access_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_allow_o(rsp_allow_o),
    .win_valid_o(win_valid_o), .win_offset_o(win_offset_o), .chk_addr_o(chk_addr_o),
    .chk_sid_o(chk_sid_o), .chk_access_o(chk_access_o), .entry_match_i(entry_match_i),
    .entry_allow_i(entry_allow_i), .entry_sid_ok_i(entry_sid_ok_i),
    .err_valid_o(err_valid_o), .err_type_o(err_type_o), .err_eid_o(err_eid_o),
    .err_sid_o(err_sid_o), .err_addr_o(err_addr_o)
  );

  // Entry table seen by the analyzer array; entries NE..TBL-1 are phantom lanes.
  logic [TBL-1:0] tbl_match = '0;
  logic [TBL-1:0] tbl_allow = '0;
  logic [TBL-1:0] tbl_sid   = '0;

  always_comb begin
    entry_match_i  = '0;
    entry_allow_i  = '0;
    entry_sid_ok_i = '0;
    for (int i = 0; i < NA; i++) begin
      if (int'(win_offset_o) + i < TBL) begin
        entry_match_i[i]  = tbl_match[int'(win_offset_o) + i];
        entry_allow_i[i]  = tbl_allow[int'(win_offset_o) + i];
        entry_sid_ok_i[i] = tbl_sid[int'(win_offset_o) + i];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int model_rr = 0;

  int              obs_grant, obs_lat, obs_err_cnt;
  logic            obs_allow, obs_stable, obs_ready_busy, obs_timeout;
  logic [2:0]      obs_etype;
  logic [15:0]     obs_eid;
  logic [SW-1:0]   obs_esid, obs_chk_sid;
  logic [AW-1:0]   obs_eaddr, obs_chk_addr;
  logic [1:0]      obs_chk_acc;
  int              obs_off[21];

  logic            exp_allow, exp_err;
  logic [2:0]      exp_etype;
  logic [15:0]     exp_eid;
  int              exp_lat;

  // Reference: first matching entry in index order decides; its window sets latency.
  function automatic void model(input logic en, input logic [1:0] acc);
    exp_allow = 1'b0; exp_err = 1'b0; exp_etype = '0; exp_eid = '0;
    if (!en) begin
      exp_lat = 1;
      return;
    end
    for (int e = 0; e < NE; e++) begin
      if (tbl_match[e] && tbl_sid[e]) begin
        exp_lat = 2 + e / NA;
        if (tbl_allow[e]) exp_allow = 1'b1;
        else begin
          exp_err = 1'b1; exp_etype = {1'b0, acc}; exp_eid = 16'(e);
        end
        return;
      end
    end
    exp_err = 1'b1; exp_etype = 3'd5; exp_eid = '0; exp_lat = 1 + NUM_WIN;
  endfunction

  function automatic int expected_grant(input logic [NC-1:0] mask);
    for (int i = 0; i < NC; i++) begin
      if (mask[(model_rr + i) % NC]) return (model_rr + i) % NC;
    end
    return -1;
  endfunction

  task automatic set_req(input int c, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [1:0] acc);
    req_addr_i[c*AW +: AW] = a;
    req_sid_i[c*SW +: SW]  = s;
    req_access_i[c*2 +: 2] = acc;
  endtask

  task automatic clear_tbl;
    tbl_match = '0; tbl_allow = '0; tbl_sid = '0;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = '0; cfg_changed_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    model_rr = 0;
  endtask

  // Drives one request to completion and records what the DUT did; called at a negedge in IDLE.
  task automatic do_txn(input logic [NC-1:0] mask, input int cfg_lat, input int dis_lat,
                        input int stall, input logic keep);
    int n;
    logic got_rsp;
    logic [NC-1:0] onehot;
    obs_grant = -1; obs_lat = 0; obs_err_cnt = 0; obs_allow = 1'b0;
    obs_stable = 1'b1; obs_ready_busy = 1'b0; obs_timeout = 1'b0;
    obs_etype = '0; obs_eid = '0; obs_esid = '0; obs_eaddr = '0;
    for (int i = 0; i < 21; i++) obs_off[i] = -1;
    req_valid_i = mask;
    n = 0;
    #1;
    while (req_ready_o == '0 && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    if (req_ready_o == '0) begin
      obs_timeout = 1'b1; req_valid_i = '0;
      return;
    end
    for (int c = 0; c < NC; c++) if (req_ready_o[c]) obs_grant = c;
    @(negedge clk_i);
    obs_lat = 1; got_rsp = 1'b0;
    while (!got_rsp && obs_lat < 20) begin
      cfg_changed_i = (obs_lat == cfg_lat);
      if (obs_lat == dis_lat) iopmp_enabled_i = 1'b0;
      #1;
      if (obs_lat == 1) begin
        obs_chk_addr = chk_addr_o; obs_chk_sid = chk_sid_o; obs_chk_acc = chk_access_o;
      end
      if (win_valid_o) obs_off[obs_lat] = int'(win_offset_o);
      if (req_ready_o != '0) obs_ready_busy = 1'b1;
      if (err_valid_o) begin
        obs_err_cnt++; obs_etype = err_type_o; obs_eid = err_eid_o;
        obs_esid = err_sid_o; obs_eaddr = err_addr_o;
      end
      if (rsp_valid_o[obs_grant]) got_rsp = 1'b1;
      else begin
        @(negedge clk_i); obs_lat++;
      end
    end
    cfg_changed_i = 1'b0;
    if (!got_rsp) begin
      obs_timeout = 1'b1;
      do_reset();
      return;
    end
    obs_allow = rsp_allow_o;
    onehot = '0;
    onehot[obs_grant] = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i); #1;
      if (rsp_valid_o !== onehot || rsp_allow_o !== obs_allow) obs_stable = 1'b0;
      if (err_valid_o || err_type_o != 0 || err_eid_o != 0) obs_err_cnt++;
      if (req_ready_o != '0) obs_ready_busy = 1'b1;
    end
    rsp_ready_i[obs_grant] = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = '0;
    if (!keep) req_valid_i = '0;
    model_rr = (obs_grant + 1) % NC;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    req_valid_i = '1;
    #1;
    checks++;
    if (req_ready_o !== '0 || rsp_valid_o !== '0 || win_valid_o !== 1'b0 || err_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%0b rsp=%0b win=%0b err=%0b, want all 0",
               req_ready_o, rsp_valid_o, win_valid_o, err_valid_o);
    end
    checks++;
    if (rsp_allow_o !== 1'b0 || chk_addr_o !== '0 || win_offset_o !== '0 || err_addr_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: allow=%0b addr=%0h off=%0d, want 0", rsp_allow_o, chk_addr_o, win_offset_o);
    end
    req_valid_i = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_allow;
    clear_tbl();
    tbl_match[3] = 1'b1; tbl_allow[3] = 1'b1; tbl_sid[3] = 1'b1;
    set_req(0, 64'h1000, 8'h11, 2'd1);
    model(1'b1, 2'd1);
    do_txn(2'b01, -1, -1, 0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_grant !== 0) begin
      errors++; $display("[TB] FAIL single_grant: got ch %0d timeout %0b, want ch 0", obs_grant, obs_timeout);
    end
    checks++;
    if (obs_lat !== exp_lat || exp_lat !== 2) begin
      errors++; $display("[TB] FAIL single_latency: got %0d, want 2", obs_lat);
    end
    checks++;
    if (obs_allow !== 1'b1 || obs_err_cnt !== 0) begin
      errors++; $display("[TB] FAIL single_allow: allow %0b errs %0d, want 1/0", obs_allow, obs_err_cnt);
    end
    checks++;
    if (obs_chk_addr !== 64'h1000 || obs_chk_sid !== 8'h11 || obs_chk_acc !== 2'd1) begin
      errors++; $display("[TB] FAIL single_capture: addr %0h sid %0h acc %0d", obs_chk_addr, obs_chk_sid, obs_chk_acc);
    end
  endtask

  task automatic test_priority;
    clear_tbl();
    tbl_match[20] = 1'b1; tbl_sid[20] = 1'b1; tbl_allow[20] = 1'b0;
    tbl_match[25] = 1'b1; tbl_sid[25] = 1'b1; tbl_allow[25] = 1'b1;
    set_req(1, 64'hABCD_0000_1234, 8'h5A, 2'd1);
    model(1'b1, 2'd1);
    do_txn(2'b10, -1, -1, 2, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_lat !== exp_lat || obs_allow !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_rsp: lat %0d allow %0b, want %0d/0", obs_lat, obs_allow, exp_lat);
    end
    checks++;
    if (obs_err_cnt !== 1 || obs_etype !== 3'd1 || obs_eid !== 16'd20) begin
      errors++; $display("[TB] FAIL prio_err: pulses %0d type %0d eid %0d, want 1/1/20", obs_err_cnt, obs_etype, obs_eid);
    end
    checks++;
    if (obs_esid !== 8'h5A || obs_eaddr !== 64'hABCD_0000_1234) begin
      errors++; $display("[TB] FAIL prio_err_fields: sid %0h addr %0h", obs_esid, obs_eaddr);
    end
  endtask

  task automatic test_ragged;
    clear_tbl();
    for (int e = NE; e < TBL; e++) begin
      tbl_match[e] = 1'b1; tbl_sid[e] = 1'b1; tbl_allow[e] = 1'b0;
    end
    set_req(0, 64'h2000, 8'h01, 2'd2);
    model(1'b1, 2'd2);
    do_txn(2'b01, -1, -1, 0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_lat !== 4 || obs_allow !== 1'b0) begin
      errors++; $display("[TB] FAIL ragged_rsp: lat %0d allow %0b, want 4/0", obs_lat, obs_allow);
    end
    checks++;
    if (obs_err_cnt !== 1 || obs_etype !== exp_etype || obs_eid !== exp_eid) begin
      errors++; $display("[TB] FAIL ragged_err: pulses %0d type %0d eid %0d, want 1/5/0", obs_err_cnt, obs_etype, obs_eid);
    end
    checks++;
    if (obs_off[1] !== 0 || obs_off[2] !== NA || obs_off[3] !== 2*NA) begin
      errors++; $display("[TB] FAIL ragged_offsets: %0d %0d %0d, want 0 16 32", obs_off[1], obs_off[2], obs_off[3]);
    end
  endtask

  task automatic test_arbitration;
    int exp_g;
    clear_tbl();
    tbl_match[0] = 1'b1; tbl_sid[0] = 1'b1; tbl_allow[0] = 1'b1;
    set_req(0, 64'h10, 8'h1, 2'd1);
    set_req(1, 64'h20, 8'h2, 2'd3);
    for (int k = 0; k < 4; k++) begin
      exp_g = expected_grant(2'b11);
      do_txn(2'b11, -1, -1, (k == 1) ? 5 : 0, 1'b1);
      checks++;
      if (obs_timeout !== 1'b0 || obs_grant !== exp_g) begin
        errors++; $display("[TB] FAIL arb_grant%0d: got ch %0d, want ch %0d", k, obs_grant, exp_g);
      end
      checks++;
      if (obs_stable !== 1'b1 || obs_allow !== 1'b1 || obs_ready_busy !== 1'b0) begin
        errors++; $display("[TB] FAIL arb_hold%0d: stable %0b allow %0b busy %0b", k, obs_stable, obs_allow, obs_ready_busy);
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_cfg_change;
    int base_lat;
    clear_tbl();
    tbl_match[20] = 1'b1; tbl_sid[20] = 1'b1; tbl_allow[20] = 1'b1;
    set_req(0, 64'h3000, 8'h3, 2'd1);
    model(1'b1, 2'd1);
    do_txn(2'b01, -1, -1, 0, 1'b0);
    base_lat = obs_lat;
    checks++;
    if (obs_timeout !== 1'b0 || base_lat !== exp_lat) begin
      errors++; $display("[TB] FAIL cfg_base_latency: got %0d, want %0d", base_lat, exp_lat);
    end
    do_txn(2'b01, 2, -1, 0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_lat !== exp_lat + 2 || obs_allow !== 1'b1) begin
      errors++; $display("[TB] FAIL cfg_latency: got %0d allow %0b, want %0d/1", obs_lat, obs_allow, exp_lat + 2);
    end
    checks++;
    if (obs_off[2] !== NA || obs_off[3] !== 0) begin
      errors++; $display("[TB] FAIL cfg_restart: offsets %0d %0d, want 16 0", obs_off[2], obs_off[3]);
    end
  endtask

  task automatic test_disabled;
    clear_tbl();
    tbl_match[5] = 1'b1; tbl_sid[5] = 1'b1; tbl_allow[5] = 1'b1;
    set_req(1, 64'h4000, 8'h4, 2'd2);
    iopmp_enabled_i = 1'b0;
    model(1'b0, 2'd2);
    do_txn(2'b10, -1, -1, 1, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_lat !== exp_lat || obs_allow !== 1'b0 || obs_err_cnt !== 0) begin
      errors++; $display("[TB] FAIL disabled_grant: lat %0d allow %0b errs %0d, want 1/0/0", obs_lat, obs_allow, obs_err_cnt);
    end
    iopmp_enabled_i = 1'b1;
    clear_tbl();
    do_txn(2'b10, -1, 2, 0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_lat !== 3 || obs_allow !== 1'b0 || obs_err_cnt !== 0) begin
      errors++; $display("[TB] FAIL disabled_scan: lat %0d allow %0b errs %0d, want 3/0/0", obs_lat, obs_allow, obs_err_cnt);
    end
    iopmp_enabled_i = 1'b1;
  endtask

  task automatic test_random;
    int c;
    logic en;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [1:0] acc;
    for (int it = 0; it < 24; it++) begin
      for (int e = 0; e < TBL; e++) begin
        tbl_match[e] = ($urandom_range(0, 9) == 0);
        tbl_sid[e]   = ($urandom_range(0, 3) != 0);
        tbl_allow[e] = $urandom_range(0, 1) != 0;
      end
      c   = $urandom_range(0, NC - 1);
      en  = ($urandom_range(0, 7) != 0);
      a   = {$urandom, $urandom};
      s   = SW'($urandom);
      acc = 2'($urandom_range(1, 3));
      set_req(c, a, s, acc);
      iopmp_enabled_i = en;
      model(en, acc);
      do_txn(NC'(1) << c, -1, -1, $urandom_range(0, 2), 1'b0);
      checks++;
      if (obs_timeout !== 1'b0 || obs_grant !== c || obs_lat !== exp_lat) begin
        errors++; $display("[TB] FAIL rand%0d_timing: ch %0d lat %0d, want ch %0d lat %0d", it, obs_grant, obs_lat, c, exp_lat);
      end
      checks++;
      if (obs_allow !== exp_allow || obs_err_cnt !== (exp_err ? 1 : 0)) begin
        errors++; $display("[TB] FAIL rand%0d_decision: allow %0b errs %0d, want %0b/%0b", it, obs_allow, obs_err_cnt, exp_allow, exp_err);
      end
      checks++;
      if (obs_chk_addr !== a || obs_chk_sid !== s || obs_chk_acc !== acc) begin
        errors++; $display("[TB] FAIL rand%0d_capture: addr %0h sid %0h acc %0d", it, obs_chk_addr, obs_chk_sid, obs_chk_acc);
      end
      if (exp_err) begin
        checks++;
        if (obs_etype !== exp_etype || obs_eid !== exp_eid || obs_esid !== s || obs_eaddr !== a) begin
          errors++; $display("[TB] FAIL rand%0d_err: type %0d eid %0d, want %0d/%0d", it, obs_etype, obs_eid, exp_etype, exp_eid);
        end
      end
    end
    iopmp_enabled_i = 1'b1;
  endtask

  task automatic test_reset_mid_scan;
    clear_tbl();
    set_req(0, 64'hDEAD, 8'h7, 2'd1);
    set_req(1, 64'hBEEF, 8'h8, 2'd1);
    req_valid_i = 2'b01;
    #1;
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    #1;
    checks++;
    if (win_valid_o !== 1'b1 || chk_addr_o !== 64'hDEAD) begin
      errors++; $display("[TB] FAIL midscan_setup: win %0b addr %0h, want 1/dead", win_valid_o, chk_addr_o);
    end
    req_valid_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (win_valid_o !== 1'b0 || rsp_valid_o !== '0 || req_ready_o !== '0 || err_valid_o !== 1'b0 ||
        chk_addr_o !== '0 || win_offset_o !== '0) begin
      errors++; $display("[TB] FAIL midscan_reset: win %0b rsp %0b ready %0b addr %0h, want 0",
                         win_valid_o, rsp_valid_o, req_ready_o, chk_addr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++; $display("[TB] FAIL midscan_rr: ready %0b, want 01", req_ready_o);
    end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_allow();
    test_priority();
    test_ragged();
    test_arbitration();
    test_cfg_change();
    test_disabled();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
